reset_sequencer: RTL

RESET_SEQUENCER -- requirements
Module: reset_sequencer

---
 rtl/reset_sequencer_pkg.sv | 8 +
 rtl/reset_sequencer_bit_sync.sv | 24 ++
 rtl/reset_sequencer.sv | 90 +++++++++
 3 files changed

// File: rtl/reset_sequencer_pkg.sv
// reset_seq_pkg: state type and counter sizing helper shared by the reset sequencer.
package reset_seq_pkg;
    typedef enum logic [1:0] {IDLE, ASSERT, WAIT_ACK, RELEASE} state_t;

    function automatic int max3(input int a, input int b, input int c);
        return (a > b) ? ((a > c) ? a : c) : ((b > c) ? b : c);
    endfunction
endpackage

// File: rtl/reset_sequencer_bit_sync.sv
// bit_sync: two-flop per-bit synchronizer, cleared asynchronously with the sequencer reset.
module bit_sync #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_in,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);
    (* ASYNC_REG = "TRUE" *) logic [W-1:0] r_meta = '0;
    (* ASYNC_REG = "TRUE" *) logic [W-1:0] r_sync = '0;

    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;
endmodule

// File: rtl/reset_sequencer.sv
// reset_sequencer: holds all domain resets, waits for acks (or times out), then releases
// domains one at a time, bit 0 first, spaced GAP cycles apart.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int N_DOM      = 4,
    parameter int MIN_ASSERT = 16,
    parameter int GAP        = 8,
    parameter int TIMEOUT    = 1024
) (
    input  logic             clk,
    input  logic             rst_in,
    input  logic             req,
    input  logic [N_DOM-1:0] dom_ack,
    output logic [N_DOM-1:0] dom_rst,
    output logic             busy,
    output logic             timeout_err
);
    localparam int CW = $clog2(max3(MIN_ASSERT, GAP, TIMEOUT) + 1);
    localparam int IW = $clog2(N_DOM) + 1;

    state_t           r_state   = ASSERT;
    logic [CW-1:0]    r_cnt     = '0;
    logic [IW-1:0]    r_idx     = '0;
    logic [N_DOM-1:0] r_dom_rst = '1;
    logic             r_busy    = 1'b1;
    logic             r_err     = 1'b0;
    logic [N_DOM-1:0] w_ack;

    bit_sync #(.W(N_DOM)) u_ack_sync (
        .clk   (clk),
        .rst_in(rst_in),
        .i_d   (dom_ack),
        .o_q   (w_ack)
    );

    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            r_state   <= ASSERT;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_dom_rst <= '1;
            r_busy    <= 1'b1;
            r_err     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (req) begin
                    r_state   <= ASSERT;
                    r_cnt     <= '0;
                    r_dom_rst <= '1;
                    r_busy    <= 1'b1;
                    r_err     <= 1'b0;
                end
                ASSERT: if (r_cnt == CW'(MIN_ASSERT - 1)) begin
                    r_state <= WAIT_ACK;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
                // Acks win over the timeout when both land on the final cycle.
                WAIT_ACK: if (&w_ack || r_cnt == CW'(TIMEOUT - 1)) begin
                    r_state   <= RELEASE;
                    r_cnt     <= '0;
                    r_idx     <= '0;
                    r_dom_rst <= r_dom_rst & ~N_DOM'(1);
                    r_err     <= r_err | ~&w_ack;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
                RELEASE: if (r_cnt == CW'(GAP - 1)) begin
                    r_cnt <= '0;
                    if (r_idx == IW'(N_DOM - 1)) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_idx     <= r_idx + 1'b1;
                        r_dom_rst <= r_dom_rst & ~(N_DOM'(1) << (r_idx + 1'b1));
                    end
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign dom_rst     = r_dom_rst;
    assign busy        = r_busy;
    assign timeout_err = r_err;
endmodule
